// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. An operation
// is accepted in IDLE (round robin when both requesters are valid), executes
// for one cycle in EXEC while the ALU result is captured, and is then
// presented in RESP until the owning requester consumes it. One operation is
// in flight at a time, so back-to-back throughput is one operation per three
// cycles.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   reqN_valid/reqN_ready  request handshake for requester N (ready is a
//                          combinational accept strobe, only in IDLE)
//   reqN_a/reqN_b/reqN_op  operands and opaque 4-bit op code of requester N
//   rspN_valid/rspN_ready  response handshake for requester N
//   rsp_data               result, shared by both response channels
//   alu_a/alu_b/alu_op     drive the shared ALU from the operand registers
//   alu_out                ALU result
//   busy                   high whenever the arbiter is not in IDLE
//   ops_done               wrapping count of completed response handshakes
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_data,

  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_out,

  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        grant;       // requester owning the operation in flight
  logic        last_grant;  // requester whose operation completed last
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic [3:0]  opnd_op;
  logic [31:0] result;

  logic        pick;        // requester that would win an accept this cycle
  logic        accept;      // an operation is taken this cycle
  logic        rsp_hs;      // owning requester consumes the result this cycle

  // ---------------------------------------------------------------------------
  // Arbitration. On a tie the requester that was not served last wins; a lone
  // requester wins regardless of history.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    pick = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = ~last_grant;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
  end

  assign accept = (state == IDLE) && (req0_valid || req1_valid);

  // The ready strobes are combinational, so they are also masked by rst:
  // the state register is already IDLE while reset is held, and a valid
  // requester must still not see an accept.
  assign req0_ready = accept && !pick && !rst;
  assign req1_ready = accept &&  pick && !rst;

  // Only the owning requester's ready completes the response.
  assign rsp_hs = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);

  // The ALU always sees the operand registers; the op code is passed through
  // untouched.
  assign alu_a    = opnd_a;
  assign alu_b    = opnd_b;
  assign alu_op   = opnd_op;
  assign rsp_data = result;

  // ---------------------------------------------------------------------------
  // Controller. Response valids and busy are registered alongside the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;  // requester 0 wins the first tie after reset
      opnd_a     <= '0;
      opnd_b     <= '0;
      opnd_op    <= '0;
      result     <= '0;
      ops_done   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (accept) begin
            grant   <= pick;
            opnd_a  <= pick ? req1_a  : req0_a;
            opnd_b  <= pick ? req1_b  : req0_b;
            opnd_op <= pick ? req1_op : req0_op;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end

        EXEC: begin
          result     <= alu_out;
          rsp0_valid <= ~grant;
          rsp1_valid <=  grant;
          state      <= RESP;
        end

        RESP: begin
          if (rsp_hs) begin
            last_grant <= grant;
            ops_done   <= ops_done + CNT_W'(1);
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol properties (simulation only; ignored by synthesis).
  // ---------------------------------------------------------------------------
  a_one_ready : assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));

  a_one_rsp : assert property (@(posedge clk) disable iff (rst)
    !(rsp0_valid && rsp1_valid));

  a_rsp0_hold : assert property (@(posedge clk) disable iff (rst)
    (rsp0_valid && !rsp0_ready) |=> (rsp0_valid && $stable(rsp_data)));

  a_rsp1_hold : assert property (@(posedge clk) disable iff (rst)
    (rsp1_valid && !rsp1_ready) |=> (rsp1_valid && $stable(rsp_data)));

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-002 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; asynchronous and active-high.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1: requester N presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1: operation of requester N accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32: operands (A = shift amount for shifts, B = data).
REQ-007 SHALL have ports req0_op/req1_op, input, 4: ALU operation code from the controller constants.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid, output, 1: result for requester N available.
REQ-009 SHALL have ports rsp0_ready/rsp1_ready, input, 1: requester N consumes its result.
REQ-010 SHALL have port rsp_data, output, 32: result shared by both response channels.
REQ-011 SHALL have ports alu_a and alu_b, output, 32, and alu_op, output, 4: drive the shared combinational ALU.
REQ-012 SHALL have port alu_out, input, 32: the ALU result.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port ops_done, output, CNT_W: count of completed response handshakes.

Function
REQ-015 SHALL implement the states IDLE, EXEC and RESP.
REQ-016 In IDLE with at least one reqN_valid, SHALL grant exactly one requester, assert only that reqN_ready (combinationally), latch its a/b/op into operand registers and its index into grant, and move to EXEC.
REQ-017 If both requesters are valid in IDLE, SHALL grant the one not served last (round robin via last_grant).
REQ-018 If only one requester is valid, SHALL grant it regardless of last_grant.
REQ-019 SHALL hold reqN_ready low in EXEC and RESP, and low in IDLE for any requester that is not granted.
REQ-020 SHALL drive alu_a, alu_b and alu_op from the operand registers in all states.
REQ-021 In EXEC, SHALL capture alu_out into the result register and move to RESP after exactly one cycle.
REQ-022 In RESP, SHALL assert rsp_valid only for the granted requester, with rsp_data equal to the result register.
REQ-023 SHALL hold rsp_valid and rsp_data stable until the matching rspN_ready is sampled high.
REQ-024 On the RESP handshake, SHALL set last_grant to grant, increment ops_done (wrapping from all-ones to 0), and return to IDLE.
REQ-025 SHALL ignore rspN_ready for the non-granted requester, and any rspN_ready in IDLE/EXEC.
REQ-026 Latency: from the accept edge, rsp_valid SHALL assert 2 cycles later; back-to-back throughput SHALL be one operation per 3 cycles.
REQ-027 SHALL treat ALU op codes as opaque: no decoding, full 4-bit pass-through.

Reset
REQ-028 While rst is high, SHALL force state to IDLE, last_grant to 1 (requester 0 wins the first tie), grant, operands and result to 0, and ops_done to 0; all ready/valid outputs and busy SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL abandon that operation with no response and no ops_done increment.

Verification
REQ-030 Single request: req0 a=5, b=7, op=ALU_ADD -> req0_ready in the accept cycle; rsp0_valid 2 cycles later with rsp_data=12; ops_done=1.
REQ-031 Tie: both valid (req0 op=ALU_SUB 10,3; req1 op=ALU_OR 0xF0,0x0F) held after reset -> req0 served first (data 7), then req1 (data 0xFF); the next tie goes to req0 again.
REQ-032 Stall: rsp1_ready held low 5 cycles after rsp1_valid -> rsp1_valid and rsp_data stable, busy=1, no new grant; grant occurs 1 cycle after the handshake.
REQ-033 Shift: req1 a=4, b=0x80000000, op=ALU_SRA -> rsp_data=0xF8000000 (ALU sign extension observed through the arbiter).
REQ-034 Reset in EXEC -> all outputs 0 and state IDLE immediately (asynchronously); a pending request is re-granted after release; ops_done not incremented.
REQ-035 Wrap: CNT_W=2, complete 5 operations -> ops_done sequence 1,2,3,0,1.
